// File: rtl/video_pkg.sv
// Shared text-mode video constants and the fetch-stage record.
package video_pkg;
    localparam int COLS           = 80;
    localparam int ROWS           = 25;
    localparam int CHAR_W         = 8;
    localparam int CHAR_H         = 16;
    localparam int ADDR_BITS      = 11;
    localparam int FONT_ADDR_BITS = 12;
    localparam int CHAR_BITS      = 8;
    localparam int SCAN_W         = FONT_ADDR_BITS - CHAR_BITS;
    localparam int COL_W          = 7;
    localparam int ROW_W          = 5;

    // What travels with a character fetch from the buffer read to the ROM read
    typedef struct packed {
        logic              vld;
        logic [SCAN_W-1:0] scan;
        logic              hit;
    } fetch_t;
endpackage

// File: rtl/text_raster_counter.sv
// Raster position counters for the text grid; advances one step per visible pixel.
module text_raster_counter import video_pkg::*; #(
    parameter int COLS      = video_pkg::COLS,
    parameter int ROWS      = video_pkg::ROWS,
    parameter int CHAR_W    = video_pkg::CHAR_W,
    parameter int CHAR_H    = video_pkg::CHAR_H,
    parameter int ADDR_BITS = video_pkg::ADDR_BITS,
    localparam int PX_W     = $clog2(CHAR_W)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 frame_start,
    input  logic                 pixel_en,
    output logic [PX_W-1:0]      px,
    output logic [COL_W-1:0]     col,
    output logic [SCAN_W-1:0]    scan,
    output logic [ROW_W-1:0]     row,
    output logic [ADDR_BITS-1:0] row_base
);

    // Nested wrap of px -> col -> scan -> row; row_base tracks row*COLS by adding
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            px <= '0; col <= '0; scan <= '0; row <= '0; row_base <= '0;
        end else if (frame_start) begin
            px <= '0; col <= '0; scan <= '0; row <= '0; row_base <= '0;
        end else if (pixel_en) begin
            if (px == PX_W'(CHAR_W - 1)) begin
                px <= '0;
                if (col == COL_W'(COLS - 1)) begin
                    col <= '0;
                    if (scan == SCAN_W'(CHAR_H - 1)) begin
                        scan <= '0;
                        if (row == ROW_W'(ROWS - 1)) begin
                            row      <= '0;
                            row_base <= '0;
                        end else begin
                            row      <= row + 1'b1;
                            row_base <= row_base + ADDR_BITS'(COLS);
                        end
                    end else begin
                        scan <= scan + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end else begin
                px <= px + 1'b1;
            end
        end
    end

endmodule

// File: rtl/char_scanout.sv
// Character-mode scanout: buffer fetch -> font ROM lookup -> pixel serialiser with cursor.
module char_scanout import video_pkg::*; #(
    parameter int COLS      = video_pkg::COLS,
    parameter int ROWS      = video_pkg::ROWS,
    parameter int CHAR_W    = video_pkg::CHAR_W,
    parameter int CHAR_H    = video_pkg::CHAR_H,
    parameter int ADDR_BITS = video_pkg::ADDR_BITS
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      frame_start,
    input  logic                      pixel_en,
    output logic [ADDR_BITS-1:0]      buf_raddr,
    output logic                      buf_read_en,
    input  logic [CHAR_BITS-1:0]      buf_dout,
    output logic [FONT_ADDR_BITS-1:0] rom_addr,
    output logic                      rom_read_en,
    input  logic [CHAR_W-1:0]         rom_dout,
    input  logic [COL_W-1:0]          cursor_x,
    input  logic [ROW_W-1:0]          cursor_y,
    input  logic                      cursor_on,
    output logic                      pixel,
    output logic                      pixel_valid
);

    localparam int PX_W   = $clog2(CHAR_W);
    localparam int STAGES = 3;

    logic [PX_W-1:0]      px;
    logic [COL_W-1:0]     col;
    logic [SCAN_W-1:0]    scan;
    logic [ROW_W-1:0]     row;
    logic [ADDR_BITS-1:0] row_base;
    logic                 active;
    logic                 pix_go;
    logic                 fetch;
    logic                 cursor_hit;
    fetch_t               s1;
    logic                 s2_vld;
    logic                 s2_hit;
    logic [CHAR_W-1:0]    shreg;
    logic                 hit_d;
    logic [STAGES:1]      vld_pipe;

    // Pixel enables are ignored until the first clock after reset release, so the
    // counters, strobes and valid pipe never see a half-processed pixel.
    assign pix_go = pixel_en & active;

    text_raster_counter #(
        .COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .CHAR_H(CHAR_H), .ADDR_BITS(ADDR_BITS)
    ) u_cnt (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .pixel_en(pix_go),
        .px(px), .col(col), .scan(scan), .row(row), .row_base(row_base)
    );

    // Goes high one clock after reset release; masks the combinational fetch strobe in reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) active <= 1'b0;
        else          active <= 1'b1;
    end

    assign fetch       = pix_go & (px == '0);
    assign cursor_hit  = cursor_on & (col == cursor_x) & (row == cursor_y);
    assign buf_read_en = fetch;
    assign buf_raddr   = row_base + ADDR_BITS'(col);
    assign rom_read_en = s1.vld;
    assign rom_addr    = s1.vld ? {buf_dout, s1.scan} : '0;

    // Carry scanline and cursor flag alongside the two memory reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1     <= '0;
            s2_vld <= 1'b0;
            s2_hit <= 1'b0;
        end else begin
            s1     <= '{vld: fetch, scan: scan, hit: cursor_hit};
            s2_vld <= s1.vld;
            s2_hit <= s1.hit;
        end
    end

    // Load glyph row when ROM data arrives, otherwise shift one pixel per displayed pixel
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg <= '0;
            hit_d <= 1'b0;
        end else if (s2_vld) begin
            shreg <= rom_dout;
            hit_d <= s2_hit;
        end else if (vld_pipe[STAGES]) begin
            shreg <= {shreg[CHAR_W-2:0], 1'b0};
        end
    end

    // pixel_en delayed to line up with the serialiser output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vld_pipe <= '0;
        else          vld_pipe <= {vld_pipe[STAGES-1:1], pix_go};
    end

    assign pixel_valid = vld_pipe[STAGES];
    assign pixel       = vld_pipe[STAGES] & (shreg[CHAR_W-1] ^ hit_d);

endmodule

// File: tb/tb_char_scanout.sv
// Directed bench for char_scanout with 1-cycle sync buffer/ROM models.
module tb_char_scanout;
    // Scanlines per row shortened so a full-frame walk stays short; grid stays 80x25.
    localparam int TB_COLS   = 80;
    localparam int TB_ROWS   = 25;
    localparam int TB_CHAR_H = 2;
    localparam int LINE_PX   = TB_COLS * 8;
    localparam int GAP       = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        pixel_en = 1'b0;
    logic [10:0] buf_raddr;
    logic        buf_read_en;
    logic [7:0]  buf_dout = 8'h00;
    logic [11:0] rom_addr;
    logic        rom_read_en;
    logic [7:0]  rom_dout = 8'h00;
    logic [6:0]  cur_x = 7'd0;
    logic [4:0]  cur_y = 5'd0;
    logic        cur_on = 1'b0;
    logic        pixel;
    logic        pixel_valid;

    logic        ovr41 = 1'b0;
    logic        rom_a5 = 1'b0;
    logic [7:0]  first8;
    int          checks = 0;
    int          errors = 0;

    char_scanout #(.COLS(TB_COLS), .ROWS(TB_ROWS), .CHAR_W(8), .CHAR_H(TB_CHAR_H), .ADDR_BITS(11)) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .pixel_en(pixel_en),
        .buf_raddr(buf_raddr), .buf_read_en(buf_read_en), .buf_dout(buf_dout),
        .rom_addr(rom_addr), .rom_read_en(rom_read_en), .rom_dout(rom_dout),
        .cursor_x(cur_x), .cursor_y(cur_y), .cursor_on(cur_on),
        .pixel(pixel), .pixel_valid(pixel_valid)
    );

    always #5 clk = ~clk;

    // Buffer holds addr[7:0] (optionally 0x41 at address 0); ROM returns {char[3:0], scan}
    always @(posedge clk) if (buf_read_en) buf_dout <= (ovr41 && buf_raddr == 11'd0) ? 8'h41 : buf_raddr[7:0];
    always @(posedge clk) if (rom_read_en) rom_dout <= (rom_a5 && rom_addr == 12'h410) ? 8'hA5 : rom_addr[7:0];

    function automatic logic [7:0] exp_char(input int addr);
        if (ovr41 && addr == 0) return 8'h41;
        return addr[7:0];
    endfunction

    function automatic logic exp_pix(input int row, input int sc, input int i);
        int c, p;
        logic [7:0] ch, g;
        logic hit;
        c  = i / 8;
        p  = i % 8;
        ch = exp_char(row * TB_COLS + c);
        if (rom_a5 && ch == 8'h41 && sc == 0) g = 8'hA5;
        else                                  g = {ch[3:0], sc[3:0]};
        hit = cur_on && (c == int'(cur_x)) && (row == int'(cur_y));
        return g[7 - p] ^ hit;
    endfunction

    task automatic pulse_frame_start();
        @(negedge clk); pixel_en = 1'b0; frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
    endtask

    // One full text line of pixel_en plus a short blank, checking strobes, addresses and pixels
    task automatic drive_line(input int line);
        int row, sc, i;
        logic exp_rd, exp_rr, exp_v, exp_p;
        logic [11:0] ea;
        row = line / TB_CHAR_H;
        sc  = line % TB_CHAR_H;
        for (int k = 0; k < LINE_PX + GAP; k++) begin
            @(negedge clk);
            pixel_en = (k < LINE_PX);
            frame_start = 1'b0;
            #1;
            exp_rd = (k < LINE_PX) && (k % 8 == 0);
            checks++;
            if (buf_read_en !== exp_rd) begin
                errors++; $display("FAIL buf_read_en line %0d k %0d: got %b want %b", line, k, buf_read_en, exp_rd);
            end
            if (exp_rd) begin
                checks++;
                if (buf_raddr !== 11'(row * TB_COLS + k / 8)) begin
                    errors++; $display("FAIL buf_raddr line %0d k %0d: got %0d want %0d", line, k, buf_raddr, row * TB_COLS + k / 8);
                end
            end
            exp_rr = (k >= 1) && (k - 1 < LINE_PX) && ((k - 1) % 8 == 0);
            checks++;
            if (rom_read_en !== exp_rr) begin
                errors++; $display("FAIL rom_read_en line %0d k %0d: got %b want %b", line, k, rom_read_en, exp_rr);
            end
            if (exp_rr) begin
                ea = {exp_char(row * TB_COLS + (k - 1) / 8), sc[3:0]};
                checks++;
                if (rom_addr !== ea) begin
                    errors++; $display("FAIL rom_addr line %0d k %0d: got %h want %h", line, k, rom_addr, ea);
                end
            end
            i = k - 3;
            exp_v = (i >= 0) && (i < LINE_PX);
            exp_p = exp_v ? exp_pix(row, sc, i) : 1'b0;
            checks++;
            if (pixel_valid !== exp_v) begin
                errors++; $display("FAIL pixel_valid line %0d k %0d: got %b want %b", line, k, pixel_valid, exp_v);
            end
            checks++;
            if (pixel !== exp_p) begin
                errors++; $display("FAIL pixel line %0d idx %0d: got %b want %b", line, i, pixel, exp_p);
            end
            if (i >= 0 && i < 8) first8[7 - i] = pixel;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk); pixel_en = k[0]; #1;
            checks++;
            if ({buf_raddr, rom_addr, buf_read_en, rom_read_en, pixel, pixel_valid} !== '0) begin
                errors++;
                $display("FAIL reset_outputs k %0d: got raddr %0d rom %h rd %b rr %b px %b pv %b want all 0",
                         k, buf_raddr, rom_addr, buf_read_en, rom_read_en, pixel, pixel_valid);
            end
        end
        @(negedge clk); pixel_en = 1'b0; reset_n = 1'b1;
        @(negedge clk);
        pulse_frame_start();
        drive_line(0);
    endtask

    task automatic test_raster_walk();
        pulse_frame_start();
        for (int l = 0; l < TB_ROWS * TB_CHAR_H; l++) drive_line(l);
        drive_line(0);          // row counter wrapped back to the top
        pulse_frame_start();
        drive_line(0);
    endtask

    task automatic test_glyph();
        ovr41 = 1'b1; rom_a5 = 1'b1;
        pulse_frame_start();
        drive_line(0);
        checks++;
        if (first8 !== 8'b1010_0101) begin
            errors++; $display("FAIL glyph_first8: got %b want 10100101", first8);
        end
        ovr41 = 1'b0; rom_a5 = 1'b0;
    endtask

    task automatic test_cursor();
        cur_x = 7'd2; cur_y = 5'd0; cur_on = 1'b1;
        pulse_frame_start();
        for (int l = 0; l < 2 * TB_CHAR_H; l++) drive_line(l);
        checks++;
        if (first8 === 8'h00) begin
            errors++; $display("FAIL cursor_row1_first8: got %h want nonzero", first8);
        end
        cur_on = 1'b0;
        pulse_frame_start();
        drive_line(0);
        cur_x = 7'd100; cur_on = 1'b1;
        pulse_frame_start();
        drive_line(0);
        cur_on = 1'b0; cur_x = 7'd0;
    endtask

    // frame_start after col 37 has been fetched; its pixels must still come out
    task automatic test_frame_restart();
        logic exp_v, exp_p;
        int i;
        pulse_frame_start();
        for (int k = 0; k < 306; k++) begin
            @(negedge clk);
            pixel_en = (k < 300);
            frame_start = (k == 300);
            #1;
            i = k - 3;
            exp_v = (i >= 0) && (i < 300);
            exp_p = exp_v ? exp_pix(0, 0, i) : 1'b0;
            checks++;
            if (pixel_valid !== exp_v || pixel !== exp_p) begin
                errors++; $display("FAIL restart_drain k %0d: got pv %b px %b want pv %b px %b", k, pixel_valid, pixel, exp_v, exp_p);
            end
        end
        drive_line(0);
    endtask

    task automatic test_async_reset();
        pulse_frame_start();
        for (int k = 0; k <= 160; k++) begin
            @(negedge clk); pixel_en = 1'b1; #1;
        end
        checks++;
        if (pixel_valid !== 1'b1 || buf_read_en !== 1'b1) begin
            errors++; $display("FAIL pre_reset_active: got pv %b rd %b want 1 1", pixel_valid, buf_read_en);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({buf_raddr, rom_addr, buf_read_en, rom_read_en, pixel, pixel_valid} !== '0) begin
            errors++;
            $display("FAIL async_reset_drop: got raddr %0d rom %h rd %b rr %b px %b pv %b want all 0",
                     buf_raddr, rom_addr, buf_read_en, rom_read_en, pixel, pixel_valid);
        end
        @(negedge clk); pixel_en = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        drive_line(0);
    endtask

    initial begin
        test_reset();
        test_glyph();
        test_cursor();
        test_raster_walk();
        test_frame_restart();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
